// File: rtl/bit_serializer_pkg.sv
// Shared types and limits for the bit_serializer feeder.
package ser_pkg;

   // Serializer FSM states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2,
      GAP    = 2'd3
   } ser_state_t;

   // Largest supported inter-frame gap and the counter width it needs
   localparam int unsigned SER_MAX_GAP = 15;
   localparam int unsigned SER_GAP_W   = $clog2(SER_MAX_GAP + 1);

endpackage

// File: rtl/bit_serializer.sv
// bit_serializer: parallel word in over valid/ready, MSB-first serial out.
// A one-entry holding register lets the next word queue while the current
// one shifts, so frames can stream back-to-back.
// Optional feature: define BIT_SERIALIZER_PARITY_EN to append an even-parity
// bit to every frame.
module bit_serializer
   import ser_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned GAP_CYCLES = 0,
   parameter logic        IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_start,
   output logic             busy
);

   localparam int unsigned            CNT_W       = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]       LP_LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0]       LP_CNT_ONE  = CNT_W'(1);
   localparam logic [SER_GAP_W-1:0]   LP_GAP      = SER_GAP_W'(GAP_CYCLES);
   localparam logic [SER_GAP_W-1:0]   LP_GAP_ONE  = SER_GAP_W'(1);
   localparam bit                     LP_HAS_GAP  = (GAP_CYCLES != 0);

   ser_state_t           r_state;
   logic [WIDTH-1:0]     r_hold_data;
   logic                 r_hold_full;
   logic                 r_ready;
   logic [WIDTH-1:0]     r_shift;
   logic [CNT_W-1:0]     r_bit_cnt;
   logic [SER_GAP_W-1:0] r_gap_cnt;
   logic                 r_ser_out;
   logic                 r_ser_valid;
   logic                 r_frame_start;
   logic                 r_busy;
`ifdef BIT_SERIALIZER_PARITY_EN
   logic                 r_parity;
`endif

   logic                 w_accept;
   logic                 w_last_bit;
   logic                 w_frame_end;
   logic                 w_gap_done;
   logic                 w_handoff;
   logic                 w_load;
   logic                 w_hold_nxt;
   logic                 w_busy_nxt;
   ser_state_t           w_state_nxt;

   assign data_ready  = r_ready;
   assign ser_out     = r_ser_out;
   assign ser_valid   = r_ser_valid;
   assign frame_start = r_frame_start;
   assign busy        = r_busy;

   // Handshake, load decision and next-state decode
   always_comb begin
      w_accept   = data_valid && r_ready;
      w_last_bit = (r_state == SHIFT) && (r_bit_cnt == LP_LAST_BIT);
`ifdef BIT_SERIALIZER_PARITY_EN
      w_frame_end = (r_state == PARITY);
`else
      w_frame_end = w_last_bit;
`endif
      w_gap_done = (r_state == GAP) && (r_gap_cnt == LP_GAP);
      // Point where the next frame may start without an idle cycle
      w_handoff  = (w_frame_end && !LP_HAS_GAP) || w_gap_done;
      w_load     = r_hold_full && ((r_state == IDLE) || w_handoff);
      // Accept needs an empty holder and load needs a full one: never both
      w_hold_nxt = w_load ? 1'b0 : (w_accept ? 1'b1 : r_hold_full);

      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (r_hold_full) w_state_nxt = SHIFT;
         end
         SHIFT: begin
            if (w_last_bit) begin
`ifdef BIT_SERIALIZER_PARITY_EN
               w_state_nxt = PARITY;
`else
               if (LP_HAS_GAP)       w_state_nxt = GAP;
               else if (r_hold_full) w_state_nxt = SHIFT;
               else                  w_state_nxt = IDLE;
`endif
            end
         end
`ifdef BIT_SERIALIZER_PARITY_EN
         PARITY: begin
            if (LP_HAS_GAP)       w_state_nxt = GAP;
            else if (r_hold_full) w_state_nxt = SHIFT;
            else                  w_state_nxt = IDLE;
         end
`endif
         GAP: begin
            if (w_gap_done) w_state_nxt = r_hold_full ? SHIFT : IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase

      w_busy_nxt = (w_state_nxt != IDLE) || w_hold_nxt;
   end

   // Holding register and its registered ready flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hold_data <= '0;
         r_hold_full <= 1'b0;
         r_ready     <= 1'b1;
      end else begin
         if (w_accept) r_hold_data <= data_in;
         r_hold_full <= w_hold_nxt;
         r_ready     <= !w_hold_nxt;
      end
   end

   // FSM with shifter, counters and registered serial outputs
   // The output registers hold the bit being driven in the coming cycle, so
   // the shifter keeps only the bits still to be sent.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= IDLE;
         r_shift       <= '0;
         r_bit_cnt     <= '0;
         r_gap_cnt     <= '0;
         r_ser_out     <= IDLE_LEVEL;
         r_ser_valid   <= 1'b0;
         r_frame_start <= 1'b0;
         r_busy        <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
         r_parity      <= 1'b0;
`endif
      end else begin
         r_state       <= w_state_nxt;
         r_busy        <= w_busy_nxt;
         r_frame_start <= 1'b0;
         if (w_load) begin
            r_shift       <= {r_hold_data[WIDTH-2:0], 1'b0};
            r_bit_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_ser_out     <= r_hold_data[WIDTH-1];
            r_ser_valid   <= 1'b1;
            r_frame_start <= 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
            r_parity      <= ^r_hold_data;
`endif
         end else begin
            case (r_state)
               SHIFT: begin
                  if (w_last_bit) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                     r_ser_out   <= r_parity;
                     r_ser_valid <= 1'b1;
`else
                     r_ser_out   <= IDLE_LEVEL;
                     r_ser_valid <= 1'b0;
                     r_gap_cnt   <= LP_GAP_ONE;
`endif
                  end else begin
                     r_ser_out   <= r_shift[WIDTH-1];
                     r_ser_valid <= 1'b1;
                     r_shift     <= {r_shift[WIDTH-2:0], 1'b0};
                     r_bit_cnt   <= r_bit_cnt + LP_CNT_ONE;
                  end
               end
`ifdef BIT_SERIALIZER_PARITY_EN
               PARITY: begin
                  r_ser_out   <= IDLE_LEVEL;
                  r_ser_valid <= 1'b0;
                  r_gap_cnt   <= LP_GAP_ONE;
               end
`endif
               GAP: begin
                  r_ser_out   <= IDLE_LEVEL;
                  r_ser_valid <= 1'b0;
                  if (w_gap_done) r_gap_cnt <= '0;
                  else            r_gap_cnt <= r_gap_cnt + LP_GAP_ONE;
               end
               default: begin
                  r_ser_out   <= IDLE_LEVEL;
                  r_ser_valid <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer (WIDTH=8): table of single words,
// hand sequences for streaming, backpressure, gap and mid-frame reset, and a
// randomized stream checked against a word-level reference model.
`timescale 1ns/1ps
module tb_bit_serializer;

   localparam int unsigned W     = 8;
   localparam int unsigned GAP_N = 2;
`ifdef BIT_SERIALIZER_PARITY_EN
   localparam int unsigned FL     = W + 1;
   localparam bit          PAR_EN = 1'b1;
`else
   localparam int unsigned FL     = W;
   localparam bit          PAR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready, ser_out, ser_valid, frame_start, busy;
   logic [7:0] g_data_in;
   logic       g_data_valid;
   logic       g_data_ready, g_ser_out, g_ser_valid, g_frame_start, g_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(W), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) u_dut (
      .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
      .data_ready(data_ready), .ser_out(ser_out), .ser_valid(ser_valid),
      .frame_start(frame_start), .busy(busy));

   bit_serializer #(.WIDTH(W), .GAP_CYCLES(GAP_N), .IDLE_LEVEL(1'b1)) u_gap (
      .clk(clk), .rst(rst), .data_in(g_data_in), .data_valid(g_data_valid),
      .data_ready(g_data_ready), .ser_out(g_ser_out), .ser_valid(g_ser_valid),
      .frame_start(g_frame_start), .busy(g_busy));

   // Per-cycle traces of both DUTs, sampled on the falling edge
   logic trace_en = 1'b0;
   logic tr_v[$], tr_o[$], tr_fs[$];
   logic gt_v[$], gt_o[$], gt_fs[$];
   always @(negedge clk) begin
      if (trace_en) begin
         tr_v.push_back(ser_valid);   tr_o.push_back(ser_out);   tr_fs.push_back(frame_start);
         gt_v.push_back(g_ser_valid); gt_o.push_back(g_ser_out); gt_fs.push_back(g_frame_start);
      end
   end

   // Reference model: the serial stream is each accepted word MSB-first,
   // followed by its even-parity bit when parity is built in
   logic [7:0] exp_words[$];
   logic       exp_bits_q[$];
   logic       obs_q[$];

   task automatic build_exp();
      exp_bits_q = {};
      foreach (exp_words[n]) begin
         for (int b = 7; b >= 0; b--) exp_bits_q.push_back(1'((exp_words[n] >> b) & 8'd1));
         if (PAR_EN) exp_bits_q.push_back(1'($countones(exp_words[n]) % 2));
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   task automatic cmp_bits(input string tag);
      int bad;
      build_exp();
      chk({tag, "_len"}, 64'(obs_q.size()), 64'(exp_bits_q.size()));
      bad = 0;
      for (int i = 0; i < exp_bits_q.size() && i < obs_q.size(); i++)
         if (obs_q[i] !== exp_bits_q[i]) bad++;
      chk({tag, "_bit_errs"}, 64'(bad), 64'(0));
   endtask

   // Present a word with valid held high until the DUT takes it
   task automatic present(input logic [7:0] w, output int stall);
      logic r;
      stall = 0;
      data_in = w;
      data_valid = 1'b1;
      for (int c = 0; c < 100; c++) begin
         r = data_ready;
         @(posedge clk); #1;
         if (r === 1'b1) return;
         stall++;
      end
      fail_now("present");
   endtask

   task automatic g_present(input logic [7:0] w);
      logic r;
      g_data_in = w;
      g_data_valid = 1'b1;
      for (int c = 0; c < 100; c++) begin
         r = g_data_ready;
         @(posedge clk); #1;
         if (r === 1'b1) return;
      end
      fail_now("g_present");
   endtask

   task automatic wait_idle(input bit gap_dut);
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (!gap_dut && busy === 1'b0 && ser_valid === 1'b0) return;
         if (gap_dut && g_busy === 1'b0 && g_ser_valid === 1'b0) return;
      end
      fail_now("wait_idle");
   endtask

   // Check the main-DUT trace against the model; frame_start must mark
   // every FL-th valid bit and nothing else
   task automatic analyze(input string tag, input bit contig);
      int runs, bad_fs;
      obs_q = {};
      runs = 0;
      bad_fs = 0;
      for (int i = 0; i < tr_v.size(); i++) begin
         if (tr_v[i] === 1'b1) begin
            if (tr_fs[i] !== ((obs_q.size() % FL) == 0)) bad_fs++;
            obs_q.push_back(tr_o[i]);
            if (i == 0 || tr_v[i-1] !== 1'b1) runs++;
         end else if (tr_fs[i] !== 1'b0) bad_fs++;
      end
      cmp_bits(tag);
      chk({tag, "_fs_errs"}, 64'(bad_fs), 64'(0));
      if (contig) chk({tag, "_valid_runs"}, 64'(runs), 64'(1));
   endtask

   // Single word from idle with exact latency and frame shape
   task automatic single_frame(input logic [7:0] w, input logic [7:0] eb, input logic ep);
      logic [8:0] obs, ofs, vld;
      chk("ready_before", 64'(data_ready), 64'(1));
      data_in = w;
      data_valid = 1'b1;
      @(posedge clk); #1;
      data_valid = 1'b0;
      data_in = 8'($urandom);
      @(negedge clk);
      chk("hold_stage v/rdy/busy", 64'({ser_valid, data_ready, busy}), 64'(3'b001));
      obs = '0; ofs = '0; vld = '0;
      for (int k = 0; k < FL; k++) begin
         @(negedge clk);
         obs = {obs[7:0], ser_out};
         ofs = {ofs[7:0], frame_start};
         vld = {vld[7:0], ser_valid};
      end
      chk("frame_bits", 64'(obs), PAR_EN ? 64'({eb, ep}) : 64'({1'b0, eb}));
      chk("frame_start_pos", 64'(ofs), PAR_EN ? 64'(9'h100) : 64'(9'h080));
      chk("frame_valid", 64'(vld), PAR_EN ? 64'(9'h1FF) : 64'(9'h0FF));
      @(negedge clk);
      chk("back_to_idle", 64'({ser_valid, ser_out, frame_start, busy, data_ready}), 64'(5'b00001));
   endtask

   typedef struct {
      logic [7:0] word;
      logic [7:0] exp_bits;
      logic       exp_par;
   } vec_t;
   vec_t vecs[8];

   initial begin
      #500us;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int stall, stall2;
      int s, i, r1, gl, gbad, r2, gfs_bad;

      vecs[0] = '{8'hA5, 8'b10100101, 1'b0};
      vecs[1] = '{8'h3C, 8'b00111100, 1'b0};
      vecs[2] = '{8'h07, 8'b00000111, 1'b1};
      vecs[3] = '{8'hFF, 8'b11111111, 1'b0};
      vecs[4] = '{8'h81, 8'b10000001, 1'b0};
      vecs[5] = '{8'h00, 8'b00000000, 1'b0};
      vecs[6] = '{8'h01, 8'b00000001, 1'b1};
      vecs[7] = '{8'hE9, 8'b11101001, 1'b1};

      rst = 1'b0;
      data_in = '0;   data_valid = 1'b0;
      g_data_in = '0; g_data_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset main", 64'({data_ready, ser_out, ser_valid, frame_start, busy}), 64'(5'b10000));
      chk("reset gap", 64'({g_data_ready, g_ser_out, g_ser_valid, g_frame_start, g_busy}), 64'(5'b11000));
      rst = 1'b1;

      // Table of single words from idle
      for (int v = 0; v < 8; v++) single_frame(vecs[v].word, vecs[v].exp_bits, vecs[v].exp_par);

      // Back-to-back: second word pre-held, stream must be contiguous
      exp_words = {8'hA5, 8'h3C};
      tr_v = {}; tr_o = {}; tr_fs = {}; gt_v = {}; gt_o = {}; gt_fs = {};
      trace_en = 1'b1;
      present(8'hA5, stall);
      present(8'h3C, stall);
      data_valid = 1'b0;
      chk("b2b_second_stall", 64'(stall), 64'(1));
      wait_idle(1'b0);
      @(negedge clk);
      trace_en = 1'b0;
      analyze("b2b", 1'b1);

      // Backpressure: third word waits until the second one is loaded
      exp_words = {8'h5A, 8'hC3, 8'h96};
      tr_v = {}; tr_o = {}; tr_fs = {}; gt_v = {}; gt_o = {}; gt_fs = {};
      trace_en = 1'b1;
      present(8'h5A, stall);
      present(8'hC3, stall);
      present(8'h96, stall2);
      data_valid = 1'b0;
      chk("bp_third_stall", 64'(stall2), 64'(FL - 1));
      wait_idle(1'b0);
      @(negedge clk);
      trace_en = 1'b0;
      analyze("bp", 1'b1);

      // Gap: exactly GAP_N idle-level cycles between two queued frames
      exp_words = {8'hA5, 8'h3C};
      tr_v = {}; tr_o = {}; tr_fs = {}; gt_v = {}; gt_o = {}; gt_fs = {};
      trace_en = 1'b1;
      g_present(8'hA5);
      g_present(8'h3C);
      g_data_valid = 1'b0;
      wait_idle(1'b1);
      @(negedge clk);
      trace_en = 1'b0;
      s = gt_v.size();
      for (int j = 0; j < gt_v.size(); j++) if (gt_v[j] === 1'b1) begin s = j; break; end
      chk("gap_first_frame_seen", 64'(s < gt_v.size()), 64'(1));
      r1 = 0; gl = 0; gbad = 0; r2 = 0; gfs_bad = 0;
      i = s;
      while (i < gt_v.size() && gt_v[i] === 1'b1) begin
         if (gt_fs[i] !== (i == s)) gfs_bad++;
         r1++; i++;
      end
      while (i < gt_v.size() && gt_v[i] !== 1'b1) begin
         if (gt_o[i] !== 1'b1 || gt_fs[i] !== 1'b0) gbad++;
         gl++; i++;
      end
      s = i;
      while (i < gt_v.size() && gt_v[i] === 1'b1) begin
         if (gt_fs[i] !== (i == s)) gfs_bad++;
         r2++; i++;
      end
      chk("gap_frame1_len", 64'(r1), 64'(FL));
      chk("gap_len", 64'(gl), 64'(GAP_N));
      chk("gap_idle_level_errs", 64'(gbad), 64'(0));
      chk("gap_frame2_len", 64'(r2), 64'(FL));
      chk("gap_fs_errs", 64'(gfs_bad), 64'(0));
      obs_q = {};
      foreach (gt_v[j]) if (gt_v[j] === 1'b1) obs_q.push_back(gt_o[j]);
      cmp_bits("gap");

      // Randomized stream with random producer idles
      exp_words = {};
      tr_v = {}; tr_o = {}; tr_fs = {}; gt_v = {}; gt_o = {}; gt_fs = {};
      trace_en = 1'b1;
      @(posedge clk); #1;
      for (int n = 0; n < 40; n++) begin
         int idle;
         logic [7:0] w;
         idle = ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 14)) : int'($urandom_range(0, 2));
         for (int c = 0; c < idle; c++) begin
            data_valid = 1'b0;
            data_in = 8'($urandom);
            @(posedge clk); #1;
         end
         w = 8'($urandom);
         present(w, stall);
         exp_words.push_back(w);
      end
      data_valid = 1'b0;
      wait_idle(1'b0);
      @(negedge clk);
      trace_en = 1'b0;
      analyze("random", 1'b0);

      // Reset at bit 3 of 8'hFF with a second word held, then a clean frame
      @(negedge clk);
      present(8'hFF, stall);
      present(8'h55, stall);
      data_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_reset_bit3", 64'({ser_valid, ser_out, busy}), 64'(3'b111));
      #2 rst = 1'b0;
      #1;
      chk("async_reset", 64'({ser_valid, ser_out, frame_start, busy, data_ready}), 64'(5'b00001));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      single_frame(8'h81, 8'b10000001, 1'b0);
      repeat (4) @(negedge clk);
      chk("no_residue", 64'({ser_valid, busy, data_ready}), 64'(3'b001));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Upstream feeder for the Mealy sequence detector. It accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock. The serial output drives the detector's single-bit `in` directly, so both blocks share one clock. A one-entry holding buffer lets the producer queue the next word while the current one shifts, so frames can run back-to-back with no gap.

## Interface
Parameters:
- `WIDTH`, default 8: word width in bits, minimum 2.
- `GAP_CYCLES`, default 0: number of idle cycles inserted between consecutive frames, range 0–15.
- `IDLE_LEVEL`, default 0: value driven on `ser_out` when no bit is valid.

Ports:
- `clk`  input  1  single clock; all logic is rising-edge.
- `rst`  input  1  asynchronous, active-low reset.
- `data_in`  input  WIDTH  parallel word.
- `data_valid`  input  1  producer presents `data_in`.
- `data_ready`  output  1  block can accept a word this cycle.
- `ser_out`  output  1  serial bit; connects to the detector `in`.
- `ser_valid`  output  1  `ser_out` carries a frame bit this cycle.
- `frame_start`  output  1  one-cycle pulse coincident with each frame's first bit.
- `busy`  output  1  high in any state other than IDLE, or while the holding buffer is occupied.

## Operation
- Accept rule: a word is taken on a rising edge where `data_valid && data_ready`.
- `data_ready` is `!hold_full`. It is decoded from a register with no combinational path from `data_valid`.
- Accepted words enter the holding register. The shifter loads from the holding register when:
  - it is idle, or
  - it is on its final frame bit and the gap count is zero.
- FSM states:
  - IDLE: `ser_valid`=0 and `ser_out`=`IDLE_LEVEL`. Go to SHIFT when the holding register is full.
  - SHIFT: drive `shift_reg[WIDTH-1]`, then shift left and increment the bit counter. After bit WIDTH-1, go to PARITY if enabled. Otherwise go to GAP if `GAP_CYCLES`>0. Otherwise reload and stay in SHIFT if the holding register is full, or go to IDLE if it is empty.
  - PARITY: one cycle driving the parity bit, then leave by the same exit rules as the end of SHIFT.
  - GAP: drive `IDLE_LEVEL` with `ser_valid`=0 for `GAP_CYCLES` cycles. Then go to SHIFT if the holding register is full, or IDLE if it is empty.
- Loading a new frame into the shifter clears `hold_full`.
- A new accept is allowed on the edge after `hold_full` clears. Accept and drain never happen on the same edge, because `data_ready` was 0 during the draining cycle.
- Bit counter width is `$clog2(WIDTH)`. The counter wraps to 0 at each frame load.
- Holding the producer off is lossless: `data_in` is not sampled while `data_ready`=0.

## Timing
- Reset values: `data_ready`=1, `ser_out`=`IDLE_LEVEL`, `ser_valid`=0, `frame_start`=0, `busy`=0, `hold_full`=0, FSM=IDLE, counters=0.
- Latency from idle: a word accepted at edge N puts its MSB on `ser_out`, with `frame_start`=1, during the cycle after edge N+1. That is two cycles: hold, then load.
- Frame length: WIDTH cycles, or WIDTH+1 with parity.
- Back-to-back streaming: with `GAP_CYCLES`=0 and the holding register pre-filled, the next MSB immediately follows the previous frame's last bit. `ser_valid` stays continuously high.
- All outputs are registered.
- Reset asserted mid-frame: the frame in flight and the held word are discarded, and outputs return to their reset values asynchronously. The first accept is possible on the first edge after reset deasserts.

## Configuration
- Macro: `BIT_SERIALIZER_PARITY_EN`.
- Defined: each frame gets one extra even-parity bit, `^data` (the XOR of the word), in the PARITY state with `ser_valid`=1.
- Undefined: the PARITY state and its logic are absent, and frames are exactly WIDTH bits.

## Structure
- Shared package `ser_pkg` holds:
  - the state enum `ser_state_t` (IDLE, SHIFT, PARITY, GAP);
  - the constant `SER_MAX_GAP`=15.
- No sub-module. The holding register, shifter and FSM stay in one module.

## Test plan
All scenarios use WIDTH=8.
- Single word: accept 8'hA5 from idle → bits 1,0,1,0,0,1,0,1 on consecutive cycles. `frame_start` is high on the first bit only, then the block returns to IDLE.
- Back-to-back: 8'hA5 then 8'h3C pre-held → 16 contiguous valid bits, 1010010100111100, with `frame_start` pulsing at bits 0 and 8.
- Backpressure: with `data_valid` held high, the third word is presented while the holding register is full → `data_ready`=0. That word is accepted only after the reload, and no word is lost or duplicated.
- Gap: `GAP_CYCLES`=2 with two queued words → exactly 2 cycles of `ser_valid`=0 and `ser_out`=`IDLE_LEVEL` between the frames.
- Parity (macro defined): 8'hA5 → 9th bit 0; 8'h07 → 9th bit 1.
- Reset mid-frame: assert `rst` low at bit 3 of 8'hFF → `ser_out`=`IDLE_LEVEL`, `ser_valid`=0 and `data_ready`=1 immediately. After release, 8'h81 serializes cleanly with no residue from the aborted frame.
